asm_encoder: RTL and testbench
==============================

// Module: asm_encoder
// PURPOSE
//  Serial mini-assembler front end for the 65C02 monitor. Takes ASCII characters one at a
//  time and turns each line (3-letter mnemonic, optional mode char, CR) into one 65C02
//  opcode byte plus the instruction length. It is the inverse of the opcode-to-mnemonic
//  disassembler and covers the same mnemonic set (incl. STZ/PHX/PLY/TSB/TRB/BRA/STP/INA/DEA).
// PARAMETERS
//  ERR_BYTE  8'h00  value driven on op_byte when op_err=1
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  RST         in   1  synchronous, active-high reset
//  char_in     in   8  ASCII input character
//  char_valid  in   1  char_in valid
//  char_ready  out  1  char accepted when char_valid & char_ready
//  op_byte     out  8  assembled opcode
//  op_len      out  2  instruction length in bytes, 1..3 (0 on error)
//  op_err      out  1  line rejected
//  op_valid    out  1  result valid; held until op_ready
//  op_ready    in   1  consumer accepts result when op_valid & op_ready
// BEHAVIOUR
//  - One clock (clk); reset RST is synchronous and active-high. Reset -> IDLE, char_ready=1,
//    op_valid=0, op_byte=0, op_len=0, op_err=0, letter/mode regs cleared. Reset overrides
//    everything, including a pending result or a half-received line.
//  - FSM: IDLE -> L2 -> L3 -> MODE -> (DRAIN) -> EMIT -> IDLE. The state advances only on an
//    accepted char. char_ready=1 in all states except EMIT.
//  - IDLE: space (0x20) and CR are ignored. An 'A'-'Z' is stored as letter1 -> L2.
//    Any other char sets the sticky err flag -> DRAIN.
//  - L2/L3: 'A'-'Z' stores letter2/letter3. CR -> err, EMIT. Any other char -> err, DRAIN.
//  - MODE: CR -> EMIT. The first mode char is stored. A second mode char -> err, DRAIN.
//    Mode chars: none=implied/accumulator/relative, '#'=imm, '0'=zp, '1'=zp,X, '2'=zp,Y,
//    '3'=abs, '4'=abs,X, '5'=abs,Y, '6'=(zp,X), '7'=(zp),Y, '8'=(zp), '9'=(abs),
//    '!'=(abs,X). Any other char -> err, DRAIN.
//  - DRAIN: swallow chars until CR, then -> EMIT with err=1.
//  - ESC (0x1B) accepted in any non-EMIT state: abort to IDLE, clear err, no output.
//  - The CR is accepted in cycle N. The lookup is combinational on letter/mode regs and is
//    registered, so op_valid=1 from cycle N+1. There is no bubble after handoff: a char may
//    be accepted in the same cycle op_valid & op_ready completes.
//  - Lookup: mnemonic+mode resolves to the exact 65C02 opcode. Examples: LDA# A9, LDA0 A5,
//    STA8 92, STZ4 9E, JMP9 6C, JMP! 7C, ASL(none) 0A, INA 1A, BNE D0, BRA 80, STP DB.
//    Invalid combos (e.g. LDX1, STA#, JSR0) or unknown mnemonics -> op_err=1,
//    op_byte=ERR_BYTE, op_len=0.
//  - op_len: none=1, except branches (BPL BMI BVC BVS BCC BCS BNE BEQ BRA)=2;
//    '#','0'-'2','6'-'8'=2; '3'-'5','9','!'=3.
//  - EMIT: outputs are held stable while op_valid & !op_ready. On handshake:
//    op_valid=0, err cleared, -> IDLE.
// CONFIGURATION
//  ASM_LOWERCASE_EN defined: 'a'-'z' are folded to upper case in letter positions
//    (L1..L3 only). Mode chars and '!' are unaffected.
//  ASM_LOWERCASE_EN undefined: lowercase letters are treated as illegal chars
//    (err -> DRAIN).
// TESTING
//  1 "LDA#",CR with op_ready=1 -> one op_valid pulse, op_byte=A9, op_len=2, op_err=0.
//  2 "  STZ4",CR; "BNE",CR; "JMP!",CR back-to-back -> 9E/3, D0/2, 7C/3, no lost chars.
//  3 "LDX1",CR -> op_err=1, op_byte=ERR_BYTE, op_len=0. "LD",CR -> same error result.
//  4 op_ready=0 for 10 cycles after "PHX",CR -> op_valid/op_byte=DA/op_len=1 held,
//    char_ready=0 throughout; op_ready=1 -> accepted, char_ready=1 next cycle.
//  5 "LD",ESC,"RTS",CR -> single result 60/1. "LDA#3",CR -> error (two mode chars).
//  6 RST asserted after "ST" and also while op_valid=1 pending -> all outputs at reset
//    values next cycle. "lda0",CR -> A5 with ASM_LOWERCASE_EN, op_err=1 without it.

Source files
------------

// File: rtl/asm_encoder.sv
// Serial mini-assembler: ASCII line (mnemonic, mode char, CR) -> 65C02 opcode + length.
// Optional ASM_LOWERCASE_EN folds 'a'-'z' to upper case in the three letter positions.
//
// Ports:
//   clk, RST (sync, active-high)
//   char_in[7:0], char_valid -> char_ready    : character stream in
//   op_byte[7:0], op_len[1:0], op_err, op_valid
//   op_ready                                   : result stream out
module asm_encoder #(
    parameter logic [7:0] ERR_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [7:0] op_byte,
    output logic [1:0] op_len,
    output logic       op_err,
    output logic       op_valid,
    input  logic       op_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_L2    = 3'd1;
    localparam logic [2:0] S_L3    = 3'd2;
    localparam logic [2:0] S_MODE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;

    localparam logic [3:0] M_NONE = 4'd0;
    localparam logic [3:0] M_IMM  = 4'd1;
    localparam logic [3:0] M_ZP   = 4'd2;
    localparam logic [3:0] M_ZPX  = 4'd3;
    localparam logic [3:0] M_ZPY  = 4'd4;
    localparam logic [3:0] M_ABS  = 4'd5;
    localparam logic [3:0] M_ABX  = 4'd6;
    localparam logic [3:0] M_ABY  = 4'd7;
    localparam logic [3:0] M_IZX  = 4'd8;
    localparam logic [3:0] M_IZY  = 4'd9;
    localparam logic [3:0] M_IZP  = 4'd10;
    localparam logic [3:0] M_IND  = 4'd11;
    localparam logic [3:0] M_IAX  = 4'd12;

    localparam logic [7:0] C_CR  = 8'h0D;
    localparam logic [7:0] C_ESC = 8'h1B;
    localparam logic [7:0] C_SP  = 8'h20;

    logic [2:0] state_q, state_d;
    logic [7:0] l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
    logic [3:0] mode_q, mode_d;
    logic       err_q, err_d;
    logic [7:0] op_byte_q, op_byte_d;
    logic [1:0] op_len_q, op_len_d;
    logic       op_err_q, op_err_d;
    logic       op_valid_q, op_valid_d;

    logic [2:0] cur;
    logic       hs, emit, is_let;
    logic [7:0] ch;
    logic [3:0] mc;
    logic [9:0] res;

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef ASM_LOWERCASE_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    // Zero means "not a mode character".
    function automatic logic [3:0] mode_of(input logic [7:0] c);
        case (c)
            "#": return M_IMM;
            "0": return M_ZP;
            "1": return M_ZPX;
            "2": return M_ZPY;
            "3": return M_ABS;
            "4": return M_ABX;
            "5": return M_ABY;
            "6": return M_IZX;
            "7": return M_IZY;
            "8": return M_IZP;
            "9": return M_IND;
            "!": return M_IAX;
            default: return M_NONE;
        endcase
    endfunction

    function automatic logic [1:0] len_of(input logic [3:0] md, input logic br);
        case (md)
            M_NONE: return br ? 2'd2 : 2'd1;
            M_IMM, M_ZP, M_ZPX, M_ZPY,
            M_IZX, M_IZY, M_IZP: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Returns {ok, branch, opcode}.
    function automatic logic [9:0] lookup(input logic [23:0] mn, input logic [3:0] md);
        logic       ok, br, alu, sh, imp;
        logic [7:0] op, b;
        ok = 1'b1; br = 1'b0; alu = 1'b0; sh = 1'b0; imp = 1'b0;
        op = 8'h00; b = 8'h00;
        case (mn)
            "ORA": begin alu = 1'b1; b = 8'h00; end
            "AND": begin alu = 1'b1; b = 8'h20; end
            "EOR": begin alu = 1'b1; b = 8'h40; end
            "ADC": begin alu = 1'b1; b = 8'h60; end
            "STA": begin alu = 1'b1; b = 8'h80; end
            "LDA": begin alu = 1'b1; b = 8'hA0; end
            "CMP": begin alu = 1'b1; b = 8'hC0; end
            "SBC": begin alu = 1'b1; b = 8'hE0; end
            "ASL": begin sh = 1'b1; b = 8'h00; end
            "ROL": begin sh = 1'b1; b = 8'h20; end
            "LSR": begin sh = 1'b1; b = 8'h40; end
            "ROR": begin sh = 1'b1; b = 8'h60; end
            "BPL": begin imp = 1'b1; br = 1'b1; op = 8'h10; end
            "BMI": begin imp = 1'b1; br = 1'b1; op = 8'h30; end
            "BVC": begin imp = 1'b1; br = 1'b1; op = 8'h50; end
            "BVS": begin imp = 1'b1; br = 1'b1; op = 8'h70; end
            "BRA": begin imp = 1'b1; br = 1'b1; op = 8'h80; end
            "BCC": begin imp = 1'b1; br = 1'b1; op = 8'h90; end
            "BCS": begin imp = 1'b1; br = 1'b1; op = 8'hB0; end
            "BNE": begin imp = 1'b1; br = 1'b1; op = 8'hD0; end
            "BEQ": begin imp = 1'b1; br = 1'b1; op = 8'hF0; end
            "BRK": begin imp = 1'b1; op = 8'h00; end
            "PHP": begin imp = 1'b1; op = 8'h08; end
            "CLC": begin imp = 1'b1; op = 8'h18; end
            "PLP": begin imp = 1'b1; op = 8'h28; end
            "SEC": begin imp = 1'b1; op = 8'h38; end
            "RTI": begin imp = 1'b1; op = 8'h40; end
            "PHA": begin imp = 1'b1; op = 8'h48; end
            "CLI": begin imp = 1'b1; op = 8'h58; end
            "PHY": begin imp = 1'b1; op = 8'h5A; end
            "RTS": begin imp = 1'b1; op = 8'h60; end
            "PLA": begin imp = 1'b1; op = 8'h68; end
            "SEI": begin imp = 1'b1; op = 8'h78; end
            "PLY": begin imp = 1'b1; op = 8'h7A; end
            "DEY": begin imp = 1'b1; op = 8'h88; end
            "TXA": begin imp = 1'b1; op = 8'h8A; end
            "TYA": begin imp = 1'b1; op = 8'h98; end
            "TXS": begin imp = 1'b1; op = 8'h9A; end
            "TAY": begin imp = 1'b1; op = 8'hA8; end
            "TAX": begin imp = 1'b1; op = 8'hAA; end
            "CLV": begin imp = 1'b1; op = 8'hB8; end
            "TSX": begin imp = 1'b1; op = 8'hBA; end
            "INY": begin imp = 1'b1; op = 8'hC8; end
            "DEX": begin imp = 1'b1; op = 8'hCA; end
            "WAI": begin imp = 1'b1; op = 8'hCB; end
            "CLD": begin imp = 1'b1; op = 8'hD8; end
            "PHX": begin imp = 1'b1; op = 8'hDA; end
            "STP": begin imp = 1'b1; op = 8'hDB; end
            "INX": begin imp = 1'b1; op = 8'hE8; end
            "NOP": begin imp = 1'b1; op = 8'hEA; end
            "SED": begin imp = 1'b1; op = 8'hF8; end
            "PLX": begin imp = 1'b1; op = 8'hFA; end
            "INA": begin imp = 1'b1; op = 8'h1A; end
            "DEA": begin imp = 1'b1; op = 8'h3A; end
            "INC": case (md)
                M_NONE: op = 8'h1A;  M_ZP:  op = 8'hE6;
                M_ZPX:  op = 8'hF6;  M_ABS: op = 8'hEE;
                M_ABX:  op = 8'hFE;  default: ok = 1'b0;
            endcase
            "DEC": case (md)
                M_NONE: op = 8'h3A;  M_ZP:  op = 8'hC6;
                M_ZPX:  op = 8'hD6;  M_ABS: op = 8'hCE;
                M_ABX:  op = 8'hDE;  default: ok = 1'b0;
            endcase
            "BIT": case (md)
                M_IMM: op = 8'h89;  M_ZP:  op = 8'h24;
                M_ZPX: op = 8'h34;  M_ABS: op = 8'h2C;
                M_ABX: op = 8'h3C;  default: ok = 1'b0;
            endcase
            "LDX": case (md)
                M_IMM: op = 8'hA2;  M_ZP:  op = 8'hA6;
                M_ZPY: op = 8'hB6;  M_ABS: op = 8'hAE;
                M_ABY: op = 8'hBE;  default: ok = 1'b0;
            endcase
            "LDY": case (md)
                M_IMM: op = 8'hA0;  M_ZP:  op = 8'hA4;
                M_ZPX: op = 8'hB4;  M_ABS: op = 8'hAC;
                M_ABX: op = 8'hBC;  default: ok = 1'b0;
            endcase
            "STX": case (md)
                M_ZP: op = 8'h86;  M_ZPY: op = 8'h96;
                M_ABS: op = 8'h8E; default: ok = 1'b0;
            endcase
            "STY": case (md)
                M_ZP: op = 8'h84;  M_ZPX: op = 8'h94;
                M_ABS: op = 8'h8C; default: ok = 1'b0;
            endcase
            "STZ": case (md)
                M_ZP:  op = 8'h64;  M_ZPX: op = 8'h74;
                M_ABS: op = 8'h9C;  M_ABX: op = 8'h9E;
                default: ok = 1'b0;
            endcase
            "CPX": case (md)
                M_IMM: op = 8'hE0;  M_ZP: op = 8'hE4;
                M_ABS: op = 8'hEC;  default: ok = 1'b0;
            endcase
            "CPY": case (md)
                M_IMM: op = 8'hC0;  M_ZP: op = 8'hC4;
                M_ABS: op = 8'hCC;  default: ok = 1'b0;
            endcase
            "TSB": case (md)
                M_ZP: op = 8'h04;  M_ABS: op = 8'h0C;
                default: ok = 1'b0;
            endcase
            "TRB": case (md)
                M_ZP: op = 8'h14;  M_ABS: op = 8'h1C;
                default: ok = 1'b0;
            endcase
            "JMP": case (md)
                M_ABS: op = 8'h4C;  M_IND: op = 8'h6C;
                M_IAX: op = 8'h7C;  default: ok = 1'b0;
            endcase
            "JSR": if (md == M_ABS) op = 8'h20; else ok = 1'b0;
            default: ok = 1'b0;
        endcase
        // ALU and shift groups share a column layout relative to their base.
        if (alu) begin
            case (md)
                M_IMM: begin op = b + 8'h09; ok = (mn != "STA"); end
                M_ZP:  op = b + 8'h05;
                M_ZPX: op = b + 8'h15;
                M_ABS: op = b + 8'h0D;
                M_ABX: op = b + 8'h1D;
                M_ABY: op = b + 8'h19;
                M_IZX: op = b + 8'h01;
                M_IZY: op = b + 8'h11;
                M_IZP: op = b + 8'h12;
                default: ok = 1'b0;
            endcase
        end else if (sh) begin
            case (md)
                M_NONE: op = b + 8'h0A;
                M_ZP:   op = b + 8'h06;
                M_ZPX:  op = b + 8'h16;
                M_ABS:  op = b + 8'h0E;
                M_ABX:  op = b + 8'h1E;
                default: ok = 1'b0;
            endcase
        end else if (imp && md != M_NONE) begin
            ok = 1'b0;
        end
        return {ok, br, op};
    endfunction

    always_comb begin
        state_d    = state_q;
        l1_d       = l1_q;
        l2_d       = l2_q;
        l3_d       = l3_q;
        mode_d     = mode_q;
        err_d      = err_q;
        op_byte_d  = op_byte_q;
        op_len_d   = op_len_q;
        op_err_d   = op_err_q;
        op_valid_d = op_valid_q;
        emit       = 1'b0;
        cur        = state_q;
        hs         = op_valid_q & op_ready;
        ch         = fold(char_in);
        mc         = mode_of(char_in);
        is_let     = (ch >= "A") && (ch <= "Z");
        res        = lookup({l1_q, l2_q, l3_q}, mode_q);

        // Handoff frees the FSM in the same cycle, so a char can land here too.
        if (hs) begin
            op_valid_d = 1'b0;
            err_d      = 1'b0;
            state_d    = S_IDLE;
            cur        = S_IDLE;
        end
        char_ready = (state_q != S_EMIT) | hs;

        if (char_valid && char_ready) begin
            if (char_in == C_ESC) begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end else begin
                case (cur)
                    S_IDLE: begin
                        if (char_in != C_SP && char_in != C_CR) begin
                            if (is_let) begin
                                l1_d    = ch;
                                l2_d    = 8'h00;
                                l3_d    = 8'h00;
                                mode_d  = M_NONE;
                                state_d = S_L2;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_DRAIN;
                            end
                        end
                    end
                    S_L2, S_L3: begin
                        if (is_let) begin
                            if (cur == S_L2) begin
                                l2_d    = ch;
                                state_d = S_L3;
                            end else begin
                                l3_d    = ch;
                                state_d = S_MODE;
                            end
                        end else if (char_in == C_CR) begin
                            err_d = 1'b1;
                            emit  = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                    S_MODE: begin
                        if (char_in == C_CR) begin
                            emit = 1'b1;
                        end else if (mc != M_NONE && mode_q == M_NONE) begin
                            mode_d = mc;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (char_in == C_CR) begin
                            err_d = 1'b1;
                            emit  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (emit) begin
            state_d    = S_EMIT;
            op_valid_d = 1'b1;
            if (err_d || !res[9]) begin
                op_err_d  = 1'b1;
                op_byte_d = ERR_BYTE;
                op_len_d  = 2'd0;
            end else begin
                op_err_d  = 1'b0;
                op_byte_d = res[7:0];
                op_len_d  = len_of(mode_q, res[8]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= S_IDLE;
            l1_q       <= 8'h00;
            l2_q       <= 8'h00;
            l3_q       <= 8'h00;
            mode_q     <= M_NONE;
            err_q      <= 1'b0;
            op_byte_q  <= 8'h00;
            op_len_q   <= 2'd0;
            op_err_q   <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            l1_q       <= l1_d;
            l2_q       <= l2_d;
            l3_q       <= l3_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            op_byte_q  <= op_byte_d;
            op_len_q   <= op_len_d;
            op_err_q   <= op_err_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign op_byte  = op_byte_q;
    assign op_len   = op_len_q;
    assign op_err   = op_err_q;
    assign op_valid = op_valid_q;

endmodule

// File: tb/tb_asm_encoder.sv
// Bench for asm_encoder: scoreboard of expected {byte,len,err} per line,
// results captured on handshake and compared inside each scenario task.
module tb_asm_encoder;

    localparam logic [7:0] ERR = 8'h00;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] ESC = 8'h1B;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] op_byte;
    logic [1:0] op_len;
    logic       op_err;
    logic       op_valid;
    logic       op_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    logic [10:0] g, e;

    asm_encoder #(.ERR_BYTE(ERR)) dut (
        .clk(clk), .RST(RST),
        .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
        .op_byte(op_byte), .op_len(op_len), .op_err(op_err),
        .op_valid(op_valid), .op_ready(op_ready)
    );

    always #5 clk = ~clk;

    // Capture each completed handshake, sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (!RST && op_valid && op_ready)
            got_q.push_back({op_byte, op_len, op_err});
    end

    function automatic logic [10:0] pk(input logic [7:0] b, input logic [1:0] l,
                                       input logic er);
        return {b, l, er};
    endfunction

    task automatic send(input logic [7:0] c);
        int t = 0;
        @(negedge clk);
        char_in = c;
        char_valid = 1'b1;
        #1;
        while (!char_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!char_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: char %h never accepted", c);
        end
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic line(input string s, input logic [10:0] x);
        exp_q.push_back(x);
        send_str(s);
        send(CR);
    endtask

    task automatic pop_pair(output logic [10:0] gg, output logic [10:0] ee);
        int t = 0;
        while (got_q.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ee = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
        gg = (got_q.size() != 0) ? got_q.pop_front() : 11'bx;
    endtask

    task automatic test_reset;
        RST = 1'b1; char_valid = 1'b0; char_in = 8'h00; op_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({char_ready, op_valid, op_byte, op_len, op_err} !== 13'b1_0_00000000_00_0) begin
            n_bad++;
            $display("FAIL reset: got rdy=%b v=%b b=%h l=%0d e=%b want 1 0 00 0 0",
                     char_ready, op_valid, op_byte, op_len, op_err);
        end
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic test_single;
        line("LDA#", pk(8'hA9, 2'd2, 1'b0));
        pop_pair(g, e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL lda_imm: got %h want %h", g, e);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL one_pulse: got %0d extra results want 0", got_q.size());
        end
    endtask

    task automatic test_back_to_back;
        line("  STZ4", pk(8'h9E, 2'd3, 1'b0));
        line("BNE", pk(8'hD0, 2'd2, 1'b0));
        line("JMP!", pk(8'h7C, 2'd3, 1'b0));
        for (int i = 0; i < 3; i++) begin
            pop_pair(g, e);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_%0d: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_lookup;
        string       s[12];
        logic [10:0] x[12];
        s = '{"JMP9", "STA8", "ASL", "INA", "BRA", "STP",
              "LDA0", "JSR0", "STA#", "LDA", "LDA?", "?X"};
        x = '{pk(8'h6C, 2'd3, 1'b0), pk(8'h92, 2'd2, 1'b0),
              pk(8'h0A, 2'd1, 1'b0), pk(8'h1A, 2'd1, 1'b0),
              pk(8'h80, 2'd2, 1'b0), pk(8'hDB, 2'd1, 1'b0),
              pk(8'hA5, 2'd2, 1'b0), pk(ERR, 2'd0, 1'b1),
              pk(ERR, 2'd0, 1'b1), pk(ERR, 2'd0, 1'b1),
              pk(ERR, 2'd0, 1'b1), pk(ERR, 2'd0, 1'b1)};
        for (int i = 0; i < 12; i++) line(s[i], x[i]);
        for (int i = 0; i < 12; i++) begin
            pop_pair(g, e);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL lookup_%s: got %h want %h", s[i], g, e);
            end
        end
    endtask

    task automatic test_errors;
        line("LDX1", pk(ERR, 2'd0, 1'b1));
        line("LD", pk(ERR, 2'd0, 1'b1));
        for (int i = 0; i < 2; i++) begin
            pop_pair(g, e);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL err_%0d: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_hold;
        op_ready = 1'b0;
        exp_q.push_back(pk(8'hDA, 2'd1, 1'b0));
        send_str("PHX");
        send(CR);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({op_valid, op_byte, op_len, op_err, char_ready} !== {1'b1, 8'hDA, 2'd1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_%0d: got v=%b b=%h l=%0d e=%b rdy=%b want 1 DA 1 0 0",
                         i, op_valid, op_byte, op_len, op_err, char_ready);
            end
        end
        @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (char_ready !== 1'b1 || op_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: got rdy=%b v=%b want 1 0", char_ready, op_valid);
        end
        pop_pair(g, e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL hold_result: got %h want %h", g, e);
        end
    endtask

    task automatic test_esc_and_double_mode;
        exp_q.push_back(pk(8'h60, 2'd1, 1'b0));
        send_str("LD");
        send(ESC);
        send_str("RTS");
        send(CR);
        line("LDA#3", pk(ERR, 2'd0, 1'b1));
        for (int i = 0; i < 2; i++) begin
            pop_pair(g, e);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL esc_mode_%0d: got %h want %h", i, g, e);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL esc_extra: got %0d extra results want 0", got_q.size());
        end
    endtask

    task automatic test_reset_mid;
        send_str("ST");
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({char_ready, op_valid, op_byte, op_len, op_err} !== 13'b1_0_00000000_00_0) begin
            n_bad++;
            $display("FAIL rst_midline: got rdy=%b v=%b b=%h l=%0d e=%b want 1 0 00 0 0",
                     char_ready, op_valid, op_byte, op_len, op_err);
        end
        RST = 1'b0;
        op_ready = 1'b0;
        send_str("LDA#");
        send(CR);
        @(negedge clk);
        #1;
        n_cmp++;
        if (op_valid !== 1'b1 || op_byte !== 8'hA9) begin
            n_bad++;
            $display("FAIL rst_pending_pre: got v=%b b=%h want 1 A9", op_valid, op_byte);
        end
        RST = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({char_ready, op_valid, op_byte, op_len, op_err} !== 13'b1_0_00000000_00_0) begin
            n_bad++;
            $display("FAIL rst_pending: got rdy=%b v=%b b=%h l=%0d e=%b want 1 0 00 0 0",
                     char_ready, op_valid, op_byte, op_len, op_err);
        end
        RST = 1'b0;
        op_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL rst_leak: got %0d results want 0", got_q.size());
        end
        line("RTS", pk(8'h60, 2'd1, 1'b0));
        pop_pair(g, e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL rst_after: got %h want %h", g, e);
        end
    endtask

    task automatic test_lowercase;
`ifdef ASM_LOWERCASE_EN
        line("lda0", pk(8'hA5, 2'd2, 1'b0));
`else
        line("lda0", pk(ERR, 2'd0, 1'b1));
`endif
        pop_pair(g, e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL lowercase: got %h want %h", g, e);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_lookup;
        test_errors;
        test_hold;
        test_esc_and_double_mode;
        test_reset_mid;
        test_lowercase;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
